sram_128_1296_arb: RTL and testbench

SRAM_128_1296_ARB -- requirements
Module: sram_128_1296_arb

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_128_1296_arb_rr_pick.sv | 29 ++
 rtl/sram_128_1296_arb.sv | 160 ++++++++++++++++
 tb/tb_sram_128_1296_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and the read-response tag for the 1296x128 dual-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned ADDR_WIDTH = 11;
  localparam int unsigned DEPTH      = 1296;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned TAG_ID_W   = 4;

  // Ownership of an in-flight macro read.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sram_128_1296_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, as a one-hot grant.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_128_1296_arb.sv
// N-requester arbiter in front of a dual-port 1296x128 SRAM macro: two grants per cycle,
// round-robin, same-address write hazard blocking, out-of-range error pulses, 2-cycle reads.
module sram_128_1296_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH      = sram_arb_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [N_REQ-1:0]            err_valid,
  output logic                        mem_csb0,
  output logic                        mem_csb1,
  output logic                        mem_web0,
  output logic                        mem_web1,
  output logic [ADDR_WIDTH-1:0]       mem_addr0,
  output logic [ADDR_WIDTH-1:0]       mem_addr1,
  output logic [DATA_WIDTH-1:0]       mem_din0,
  output logic [DATA_WIDTH-1:0]       mem_din1,
  input  logic [DATA_WIDTH-1:0]       mem_dout0,
  input  logic [DATA_WIDTH-1:0]       mem_dout1
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [N_REQ-1:0]            win0, win1_raw, win1, mask1, grant, err_d;
  logic [PTR_W-1:0]            id0, id1;
  logic [ADDR_WIDTH-1:0]       addr0, addr1;
  logic [DATA_WIDTH-1:0]       wdata0, wdata1;
  logic                        we0, we1, v0, v1_raw, v1, hazard;
  logic                        oor0, oor1, iss0, iss1;
  tag_t                        tag0_d, tag1_d;
  tag_t                        tag0_q [RD_LAT];
  tag_t                        tag1_q [RD_LAT];
  logic [N_REQ-1:0]            rsp_valid_d;
  logic [N_REQ*DATA_WIDTH-1:0] rsp_data_d;

  assign mask1 = req_valid & ~win0;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick0 (.req(req_valid), .ptr(ptr_q), .gnt(win0));
  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick1 (.req(mask1),     .ptr(ptr_q), .gnt(win1_raw));

  // Winner payload selection, hazard masking of the port-1 winner and pointer advance.
  always_comb begin
    id0    = '0;
    id1    = '0;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    we0    = 1'b0;
    we1    = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win0[i]) begin
        id0    = PTR_W'(i);
        addr0  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata0 = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        we0    = req_we[i];
      end
      if (win1_raw[i]) begin
        id1    = PTR_W'(i);
        addr1  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata1 = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        we1    = req_we[i];
      end
    end
    v0     = |win0;
    v1_raw = |win1_raw;
    hazard = v0 && v1_raw && (addr0 == addr1) && (we0 || we1);
    win1   = hazard ? '0 : win1_raw;
    v1     = v1_raw && !hazard;
    grant  = win0 | win1;
    oor0   = 32'(addr0) >= DEPTH;
    oor1   = 32'(addr1) >= DEPTH;
    iss0   = v0 && !oor0;
    iss1   = v1 && !oor1;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      err_d[i] = (win0[i] && oor0) || (win1[i] && oor1);
    end
    tag0_d.valid = iss0 && !we0;
    tag0_d.id    = TAG_ID_W'(id0);
    tag1_d.valid = iss1 && !we1;
    tag1_d.id    = TAG_ID_W'(id1);
    ptr_d = ptr_q;
    if (v1) begin
      ptr_d = PTR_W'((32'(id1) + 1) % N_REQ);
    end else if (v0) begin
      ptr_d = PTR_W'((32'(id0) + 1) % N_REQ);
    end
  end

  assign req_ready = rst_n ? grant : '0;

  // Route the oldest tag stage of each port to its owner; unowned lanes keep their data.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (tag0_q[RD_LAT-1].valid && (tag0_q[RD_LAT-1].id == TAG_ID_W'(i))) begin
        rsp_valid_d[i]                       = 1'b1;
        rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_dout0;
      end
      if (tag1_q[RD_LAT-1].valid && (tag1_q[RD_LAT-1].id == TAG_ID_W'(i))) begin
        rsp_valid_d[i]                       = 1'b1;
        rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_dout1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      mem_csb0  <= 1'b1;
      mem_csb1  <= 1'b1;
      mem_web0  <= 1'b1;
      mem_web1  <= 1'b1;
      mem_addr0 <= '0;
      mem_addr1 <= '0;
      mem_din0  <= '0;
      mem_din1  <= '0;
      err_valid <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        tag0_q[s] <= '0;
        tag1_q[s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      mem_csb0  <= !iss0;
      mem_csb1  <= !iss1;
      mem_web0  <= !(iss0 && we0);
      mem_web1  <= !(iss1 && we1);
      mem_addr0 <= iss0 ? addr0 : '0;
      mem_addr1 <= iss1 ? addr1 : '0;
      mem_din0  <= (iss0 && we0) ? wdata0 : '0;
      mem_din1  <= (iss1 && we1) ? wdata1 : '0;
      err_valid <= err_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      tag0_q[0] <= tag0_d;
      tag1_q[0] <= tag1_d;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        tag0_q[s] <= tag0_q[s-1];
        tag1_q[s] <= tag1_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_128_1296_arb.sv
// Randomized bench for sram_128_1296_arb against a transaction-level arbitration/memory model.
module tb_sram_128_1296_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1296;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, err_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_data;
  logic            mem_csb0, mem_csb1, mem_web0, mem_web1;
  logic [AW-1:0]   mem_addr0, mem_addr1;
  logic [DW-1:0]   mem_din0, mem_din1, mem_dout0, mem_dout1;

  always #5 clk = ~clk;

  sram_128_1296_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_valid(err_valid),
    .mem_csb0(mem_csb0), .mem_csb1(mem_csb1), .mem_web0(mem_web0), .mem_web1(mem_web1),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_din0(mem_din0), .mem_din1(mem_din1),
    .mem_dout0(mem_dout0), .mem_dout1(mem_dout1)
  );

  // Dual-port macro: registered read data, writes visible to reads on later edges.
  logic [DW-1:0] smem [0:2047];
  bit            smem_init;
  always @(posedge clk) begin
    if (!smem_init) begin
      for (int i = 0; i < 2048; i++) smem[i] = '0;
      mem_dout0 <= '0;
      mem_dout1 <= '0;
      smem_init = 1'b1;
    end
    if (!mem_csb0 && mem_web0) mem_dout0 <= smem[mem_addr0];
    if (!mem_csb1 && mem_web1) mem_dout1 <= smem[mem_addr1];
    if (!mem_csb0 && !mem_web0) smem[mem_addr0] = mem_din0;
    if (!mem_csb1 && !mem_web1) smem[mem_addr1] = mem_din1;
  end

  // Reference state: pending requests, memory image, and expectations keyed by cycle slot.
  bit            p_valid [N];
  logic          p_we    [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_data  [N];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] last_data [N];
  logic [N-1:0]  e_rsp [4];
  logic [N-1:0]  e_err [4];
  logic [DW-1:0] e_rdata [4][N];
  bit            e_csb0 [4];
  bit            e_csb1 [4];
  int            m_ptr;
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic arm(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[r] = 1'b1;
    p_we[r]    = we;
    p_addr[r]  = a;
    p_data[r]  = d;
  endtask

  task automatic clear_model();
    m_ptr = 0;
    for (int s = 0; s < 4; s++) begin
      e_rsp[s]  = '0;
      e_err[s]  = '0;
      e_csb0[s] = 1'b1;
      e_csb1[s] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      last_data[i] = '0;
      p_valid[i]   = 1'b0;
    end
  endtask

  // Model the effect of one accepted request on the given macro port.
  task automatic take(input int w, input int port);
    if (w < 0) return;
    if (p_addr[w] >= AW'(DEPTH)) begin
      e_err[(cyc+1)%4][w] = 1'b1;
    end else begin
      if (port == 0) e_csb0[(cyc+1)%4] = 1'b0;
      else           e_csb1[(cyc+1)%4] = 1'b0;
      if (p_we[w]) begin
        ref_mem[p_addr[w]] = p_data[w];
      end else begin
        e_rsp[(cyc+3)%4][w]   = 1'b1;
        e_rdata[(cyc+3)%4][w] = ref_mem[p_addr[w]];
      end
    end
    p_valid[w] = 1'b0;
  endtask

  task automatic cycle(output logic [N-1:0] rdy);
    int            w0, w1, r, s;
    logic [N-1:0]  exp_gnt;
    logic [N*DW-1:0] exp_data;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = p_valid[i];
      req_we[i]               = p_we[i];
      req_addr[i*AW +: AW]    = p_addr[i];
      req_wdata[i*DW +: DW]   = p_data[i];
    end
    #1;
    w0 = -1;
    w1 = -1;
    for (int k = 0; k < N; k++) begin
      r = (m_ptr + k) % N;
      if (p_valid[r]) begin
        if (w0 < 0) w0 = r;
        else if (w1 < 0) w1 = r;
      end
    end
    if (w0 >= 0 && w1 >= 0 && p_addr[w0] == p_addr[w1] && (p_we[w0] || p_we[w1])) w1 = -1;
    exp_gnt = '0;
    if (w0 >= 0) exp_gnt[w0] = 1'b1;
    if (w1 >= 0) exp_gnt[w1] = 1'b1;
    s = cyc % 4;
    rdy = req_ready;
    check("req_ready", req_ready, exp_gnt);
    check("rsp_valid", rsp_valid, e_rsp[s]);
    check("err_valid", err_valid, e_err[s]);
    check("mem_csb0", mem_csb0, e_csb0[s]);
    check("mem_csb1", mem_csb1, e_csb1[s]);
    for (int i = 0; i < N; i++) begin
      if (e_rsp[s][i]) last_data[i] = e_rdata[s][i];
      exp_data[i*DW +: DW] = last_data[i];
    end
    check("rsp_data", rsp_data, exp_data);
    e_rsp[s]  = '0;
    e_err[s]  = '0;
    e_csb0[s] = 1'b1;
    e_csb1[s] = 1'b1;
    take(w0, 0);
    take(w1, 1);
    if (w1 >= 0)      m_ptr = (w1 + 1) % N;
    else if (w0 >= 0) m_ptr = (w0 + 1) % N;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    req_we    = '1;
    req_addr  = {$urandom, $urandom};
    clear_model();
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_err_valid", err_valid, '0);
    check("rst_csb_web", {mem_csb0, mem_csb1, mem_web0, mem_web1}, 4'hF);
    check("rst_mem_addr", {mem_addr0, mem_addr1}, '0);
    check("rst_mem_din", {mem_din0, mem_din1}, '0);
    check("rst_rsp_data", rsp_data, '0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    logic [N-1:0]  rdy, prev;
    logic [AW-1:0] a;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < N; i++) begin
      p_we[i]   = 1'b0;
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    do_reset();

    // Write then read back on requester 0.
    arm(0, 1'b1, AW'(5), {16{8'hA5}});
    cycle(rdy);
    arm(0, 1'b0, AW'(5), '0);
    cycle(rdy);
    check("wr_rd_ready", rdy, 4'b0001);
    repeat (4) cycle(rdy);

    // Same-address write/read collision from a fresh pointer.
    do_reset();
    arm(1, 1'b1, AW'(7), rand128());
    arm(2, 1'b0, AW'(7), '0);
    cycle(rdy);
    check("hazard_first", rdy, 4'b0010);
    cycle(rdy);
    check("hazard_second", rdy, 4'b0100);
    repeat (3) cycle(rdy);

    // Out-of-range read.
    arm(3, 1'b0, AW'(DEPTH), '0);
    cycle(rdy);
    check("oor_ready", rdy, 4'b1000);
    repeat (3) cycle(rdy);

    // All requesters reading back-to-back.
    prev = '0;
    repeat (8) begin
      for (int i = 0; i < N; i++)
        if (!p_valid[i]) arm(i, 1'b0, AW'($urandom_range(0, DEPTH-1)), '0);
      cycle(rdy);
      check("two_grants", $countones(rdy), 2);
      check("rotation", rdy & prev, '0);
      prev = rdy;
    end
    repeat (6) cycle(rdy);

    // Random traffic with address collisions and out-of-range requests.
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 7) == 0) a = AW'(DEPTH + $urandom_range(0, 2**AW - 1 - DEPTH));
          else                           a = AW'($urandom_range(0, 15));
          arm(i, 1'($urandom_range(0, 1)), a, rand128());
        end
      end
      cycle(rdy);
    end
    repeat (8) cycle(rdy);

    // Reset with two reads in flight.
    arm(0, 1'b0, AW'(5), '0);
    arm(1, 1'b0, AW'(6), '0);
    cycle(rdy);
    check("inflight_ready", rdy, 4'b0011);
    cycle(rdy);
    do_reset();
    repeat (5) cycle(rdy);

    repeat (200) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          a = AW'($urandom_range(0, 7));
          arm(i, 1'($urandom_range(0, 1)), a, rand128());
        end
      end
      cycle(rdy);
    end
    repeat (8) cycle(rdy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
